// File: rtl/gcd_pkg.sv
// gcd_pkg: shared widths, the packed {A, B} operand word and default sizing
// for gcd_req_queue and its FIFOs.
package gcd_pkg;

   localparam int GCD_W         = 16;
   localparam int REQ_W         = 2 * GCD_W;
   localparam int DEF_DEPTH     = 4;
   localparam int DEF_TAG_W     = 4;
   localparam int DEF_TAG_DEPTH = 2;

   typedef struct packed {
      logic [GCD_W-1:0] a;
      logic [GCD_W-1:0] b;
   } gcd_req_t;

   // Pointer width that stays at least one bit wide for a single-entry FIFO.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/gcd_fifo.sv
// gcd_fifo: synchronous FIFO with asynchronous active-high reset.
// The head output reads as zero while the FIFO is empty.
module gcd_fifo
   import gcd_pkg::*;
#(
   parameter int W     = REQ_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SLOTS = 1 << PTR_W;

   logic [W-1:0]     r_mem [SLOTS];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/gcd_req_queue.sv
// gcd_req_queue: buffers host {A, B} words, issues them to gcd_coprocessor with a
// sequence tag and returns each result with its tag. GCD_REQ_STATS_EN adds stat counters.
module gcd_req_queue
   import gcd_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int TAG_W     = DEF_TAG_W,
   parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_val,
   input  logic [REQ_W-1:0] req_bits,
   output logic             req_rdy,
   output logic             operands_val,
   output logic [GCD_W-1:0] operands_bits_A,
   output logic [GCD_W-1:0] operands_bits_B,
   input  logic             operands_rdy,
   input  logic             result_val_in,
   input  logic [GCD_W-1:0] result_bits_in,
   output logic             result_rdy_out,
   output logic             resp_val,
   output logic [GCD_W-1:0] resp_bits,
   output logic [TAG_W-1:0] resp_tag,
   input  logic             resp_rdy,
   output logic             err_orphan
`ifdef GCD_REQ_STATS_EN
   ,
   output logic [15:0]      stat_issued,
   output logic [15:0]      stat_returned
`endif
);

   gcd_req_t         w_op_head;
   logic             w_op_full;
   logic             w_op_empty;
   logic [TAG_W-1:0] w_tag_head;
   logic             w_tag_full;
   logic             w_tag_empty;
   logic             w_accept;
   logic             w_issue;
   logic             w_resp_fire;
   logic             w_orphan;
   logic [TAG_W-1:0] r_tag_ctr;
   logic             r_err_orphan;

   gcd_fifo #(.W(REQ_W), .DEPTH(DEPTH)) u_op_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_accept),
      .i_data  (req_bits),
      .i_pop   (w_issue),
      .o_head  (w_op_head),
      .o_full  (w_op_full),
      .o_empty (w_op_empty)
   );

   // Holds the tags of jobs inside the coprocessor, oldest at the head.
   gcd_fifo #(.W(TAG_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_issue),
      .i_data  (r_tag_ctr),
      .i_pop   (w_resp_fire),
      .o_head  (w_tag_head),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty)
   );

   assign req_rdy         = !w_op_full;
   assign w_accept        = req_val && req_rdy;

   assign operands_val    = !w_op_empty && !w_tag_full;
   assign operands_bits_A = w_op_head.a;
   assign operands_bits_B = w_op_head.b;
   assign w_issue         = operands_val && operands_rdy;

   // A result with no outstanding tag is left stalled rather than dropped.
   assign resp_val        = result_val_in && !w_tag_empty;
   assign resp_bits       = result_bits_in;
   assign resp_tag        = w_tag_head;
   assign result_rdy_out  = resp_rdy && !w_tag_empty;
   assign w_resp_fire     = resp_val && resp_rdy;
   assign w_orphan        = result_val_in && w_tag_empty;
   assign err_orphan      = r_err_orphan;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tag_ctr    <= '0;
         r_err_orphan <= 1'b0;
      end else begin
         if (w_issue)  r_tag_ctr    <= r_tag_ctr + TAG_W'(1);
         if (w_orphan) r_err_orphan <= 1'b1;
      end
   end

`ifdef GCD_REQ_STATS_EN
   logic [15:0] r_stat_issued;
   logic [15:0] r_stat_returned;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_issued   <= '0;
         r_stat_returned <= '0;
      end else begin
         if (w_issue)     r_stat_issued   <= r_stat_issued + 16'd1;
         if (w_resp_fire) r_stat_returned <= r_stat_returned + 16'd1;
      end
   end

   assign stat_issued   = r_stat_issued;
   assign stat_returned = r_stat_returned;
`endif

endmodule

// File: tb/tb_gcd_req_queue.sv
// tb_gcd_req_queue: randomized bench with a behavioural in-order coprocessor and a
// queue-based scoreboard. Building with GCD_REQ_STATS_EN defined also covers the stat counters.
module tb_gcd_req_queue;

   localparam int DEPTH     = 4;
   localparam int TAG_DEPTH = 2;
   localparam int TAG_MOD   = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_val;
   logic [31:0] req_bits;
   logic        req_rdy;
   logic        operands_val;
   logic [15:0] operands_bits_A;
   logic [15:0] operands_bits_B;
   logic        operands_rdy;
   logic        result_val_in;
   logic [15:0] result_bits_in;
   logic        result_rdy_out;
   logic        resp_val;
   logic [15:0] resp_bits;
   logic [3:0]  resp_tag;
   logic        resp_rdy;
   logic        err_orphan;
`ifdef GCD_REQ_STATS_EN
   logic [15:0] stat_issued;
   logic [15:0] stat_returned;
`endif

   always #5 clk = ~clk;

   gcd_req_queue dut (
      .clk             (clk),
      .reset           (reset),
      .req_val         (req_val),
      .req_bits        (req_bits),
      .req_rdy         (req_rdy),
      .operands_val    (operands_val),
      .operands_bits_A (operands_bits_A),
      .operands_bits_B (operands_bits_B),
      .operands_rdy    (operands_rdy),
      .result_val_in   (result_val_in),
      .result_bits_in  (result_bits_in),
      .result_rdy_out  (result_rdy_out),
      .resp_val        (resp_val),
      .resp_bits       (resp_bits),
      .resp_tag        (resp_tag),
      .resp_rdy        (resp_rdy),
      .err_orphan      (err_orphan)
`ifdef GCD_REQ_STATS_EN
      ,
      .stat_issued     (stat_issued),
      .stat_returned   (stat_returned)
`endif
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference state: words still to send, words buffered but not issued,
   // expected {tag, gcd} of issued jobs in order, and the coprocessor pipeline.
   logic [31:0] send_q[$];
   logic [31:0] pend_q[$];
   logic [19:0] exp_q[$];
   logic [15:0] cop_val_q[$];
   int          cop_due_q[$];
   int          model_tag;

   bit req_rand;
   int ordy_mode;
   int rrdy_mode;
   int lat_max;
   bit force_orphan;
   bit f_acc, f_iss, f_resp, f_cop;

   function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
      int unsigned x = a;
      int unsigned y = b;
      int unsigned t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x[15:0];
   endfunction

   function automatic logic [31:0] rand_word();
      return {16'($urandom_range(0, 600)), 16'($urandom_range(0, 600))};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      reset          = 1'b1;
      req_val        = 1'b0;
      req_bits       = '0;
      operands_rdy   = 1'b0;
      result_val_in  = 1'b0;
      result_bits_in = '0;
      resp_rdy       = 1'b0;
      force_orphan   = 1'b0;
      req_rand       = 1'b0;
      ordy_mode      = 1;
      rrdy_mode      = 1;
      lat_max        = 2;
      send_q.delete();
      pend_q.delete();
      exp_q.delete();
      cop_val_q.delete();
      cop_due_q.delete();
      model_tag = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Drive one cycle of host and coprocessor inputs, then sample the handshakes
   // that will complete on the coming rising edge.
   task automatic drive();
      @(negedge clk);
      req_val        = (send_q.size() != 0) && (!req_rand || ($urandom_range(0, 3) != 0));
      req_bits       = (send_q.size() != 0) ? send_q[0] : $urandom;
      operands_rdy   = (ordy_mode == 1) || ((ordy_mode == 2) && ($urandom_range(0, 1) == 1));
      resp_rdy       = (rrdy_mode == 1) || ((rrdy_mode == 2) && ($urandom_range(0, 2) != 0));
      result_val_in  = force_orphan || ((cop_val_q.size() != 0) && (cop_due_q[0] <= cyc));
      result_bits_in = (cop_val_q.size() != 0) ? cop_val_q[0] : 16'($urandom);
      #1;
      f_acc  = req_val && req_rdy;
      f_iss  = operands_val && operands_rdy;
      f_resp = resp_val && resp_rdy;
      f_cop  = result_val_in && result_rdy_out;
   endtask

   // Advance the reference state by the handshakes sampled in drive().
   task automatic commit();
      logic [31:0] w;
      logic [19:0] e;
      logic [15:0] g;
      int          d;
      if (f_resp && exp_q.size() != 0) e = exp_q.pop_front();
      if (f_iss && pend_q.size() != 0) begin
         w = pend_q.pop_front();
         exp_q.push_back({4'(model_tag), gcd16(w[31:16], w[15:0])});
         model_tag = (model_tag + 1) % TAG_MOD;
         cop_val_q.push_back(gcd16(operands_bits_A, operands_bits_B));
         cop_due_q.push_back(cyc + 1 + int'($urandom_range(0, lat_max)));
      end
      if (f_acc && send_q.size() != 0) pend_q.push_back(send_q.pop_front());
      if (f_cop && cop_val_q.size() != 0) begin
         g = cop_val_q.pop_front();
         d = cop_due_q.pop_front();
      end
      cyc++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset          = 1'b1;
      req_val        = 1'b1;
      req_bits       = 32'h1234_5678;
      operands_rdy   = 1'b1;
      result_val_in  = 1'b1;
      result_bits_in = 16'hBEEF;
      resp_rdy       = 1'b1;
      @(negedge clk);
      #1;
      total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL reset_req_rdy: got %b want 1", req_rdy); end
      total++; if (operands_val !== 1'b0) begin bad++; $display("FAIL reset_operands_val: got %b want 0", operands_val); end
      total++; if ({operands_bits_A, operands_bits_B} !== 32'h0) begin bad++; $display("FAIL reset_operands_bits: got %h want 0", {operands_bits_A, operands_bits_B}); end
      total++; if (resp_val !== 1'b0) begin bad++; $display("FAIL reset_resp_val: got %b want 0", resp_val); end
      total++; if (result_rdy_out !== 1'b0) begin bad++; $display("FAIL reset_result_rdy_out: got %b want 0", result_rdy_out); end
      total++; if (resp_bits !== 16'hBEEF) begin bad++; $display("FAIL reset_resp_bits: got %h want beef", resp_bits); end
      total++; if (resp_tag !== 4'd0) begin bad++; $display("FAIL reset_resp_tag: got %h want 0", resp_tag); end
      total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL reset_err_orphan: got %b want 0", err_orphan); end
   endtask

   task automatic test_single();
      logic [15:0] want_bits [2] = '{16'd3, 16'd7};
      int got = 0;
      apply_reset();
      lat_max = 3;
      send_q.push_back({16'd27, 16'd15});
      send_q.push_back({16'd21, 16'd49});
      for (int c = 0; c < 200 && got < 2; c++) begin
         drive();
         if (c == 0) begin
            total++;
            if (f_acc !== 1'b1 || operands_val !== 1'b0) begin
               bad++; $display("FAIL single_first_latency: acc=%b operands_val=%b want acc=1 operands_val=0", f_acc, operands_val);
            end
         end
         if (c == 1) begin
            total++;
            if (operands_val !== 1'b1 || {operands_bits_A, operands_bits_B} !== {16'd27, 16'd15}) begin
               bad++; $display("FAIL single_issue: val=%b bits=%h want val=1 bits=%h", operands_val, {operands_bits_A, operands_bits_B}, {16'd27, 16'd15});
            end
         end
         if (f_resp) begin
            total++;
            if (resp_bits !== want_bits[got] || resp_tag !== 4'(got)) begin
               bad++; $display("FAIL single_resp%0d: got bits=%0d tag=%0d want bits=%0d tag=%0d", got, resp_bits, resp_tag, want_bits[got], got);
            end
            got++;
         end
         commit();
      end
      total++; if (got != 2) begin bad++; $display("FAIL single_timeout: got %0d responses want 2", got); end
   endtask

   task automatic test_burst();
      logic [31:0] words [6] = '{{16'd25, 16'd30}, {16'd19, 16'd27}, {16'd40, 16'd40},
                                 {16'd250, 16'd190}, {16'd5, 16'd250}, {16'd0, 16'd0}};
      logic [15:0] want_bits [6] = '{16'd5, 16'd1, 16'd40, 16'd10, 16'd5, 16'd0};
      int got = 0;
      apply_reset();
      ordy_mode = 0;
      for (int i = 0; i < 6; i++) send_q.push_back(words[i]);
      for (int c = 0; c < 6; c++) begin
         drive();
         total++;
         if (req_rdy !== 1'(c < DEPTH)) begin
            bad++; $display("FAIL burst_req_rdy_c%0d: got %b want %b", c, req_rdy, (c < DEPTH));
         end
         commit();
      end
      ordy_mode = 1;
      for (int c = 0; c < 300 && got < 6; c++) begin
         drive();
         if (f_resp) begin
            total++;
            if (resp_bits !== want_bits[got] || resp_tag !== 4'(got)) begin
               bad++; $display("FAIL burst_resp%0d: got bits=%0d tag=%0d want bits=%0d tag=%0d", got, resp_bits, resp_tag, want_bits[got], got);
            end
            got++;
         end
         commit();
      end
      total++; if (got != 6) begin bad++; $display("FAIL burst_timeout: got %0d responses want 6", got); end
   endtask

   task automatic test_tag_wrap();
      int got = 0;
      apply_reset();
      ordy_mode = 2;
      rrdy_mode = 2;
      lat_max   = 3;
      for (int i = 0; i < 17; i++) send_q.push_back(rand_word());
      for (int c = 0; c < 1000 && got < 17; c++) begin
         drive();
         if (f_resp) begin
            total++;
            if (exp_q.size() == 0 || {resp_tag, resp_bits} !== exp_q[0]) begin
               bad++; $display("FAIL wrap_resp%0d: got tag=%0d bits=%0d want %h", got, resp_tag, resp_bits, (exp_q.size() != 0) ? exp_q[0] : 20'h0);
            end
            if (got == 16) begin
               total++;
               if (resp_tag !== 4'd0) begin bad++; $display("FAIL wrap_tag17: got %0d want 0", resp_tag); end
            end
            got++;
         end
         commit();
      end
      total++; if (got != 17) begin bad++; $display("FAIL wrap_timeout: got %0d responses want 17", got); end
   endtask

   task automatic test_back_pressure();
      int n_iss = 0;
      int got   = 0;
      apply_reset();
      ordy_mode = 1;
      rrdy_mode = 0;
      lat_max   = 0;
      for (int i = 0; i < 4; i++) send_q.push_back(rand_word());
      for (int c = 0; c < 12; c++) begin
         drive();
         if (f_iss) n_iss++;
         if (c == 11) begin
            total++;
            if (operands_val !== 1'b0 || result_rdy_out !== 1'b0 || resp_val !== 1'b1) begin
               bad++; $display("FAIL bp_stall: operands_val=%b result_rdy_out=%b resp_val=%b want 0 0 1", operands_val, result_rdy_out, resp_val);
            end
         end
         commit();
      end
      total++; if (n_iss != TAG_DEPTH) begin bad++; $display("FAIL bp_issue_count: got %0d want %0d", n_iss, TAG_DEPTH); end
      rrdy_mode = 1;
      for (int c = 0; c < 200 && got < 4; c++) begin
         drive();
         if (f_iss) n_iss++;
         if (f_resp) begin
            total++;
            if (exp_q.size() == 0 || {resp_tag, resp_bits} !== exp_q[0]) begin
               bad++; $display("FAIL bp_resp%0d: got tag=%0d bits=%0d want %h", got, resp_tag, resp_bits, (exp_q.size() != 0) ? exp_q[0] : 20'h0);
            end
            got++;
         end
         commit();
      end
      total++; if (got != 4 || n_iss != 4) begin bad++; $display("FAIL bp_drain: got %0d responses %0d issues want 4 4", got, n_iss); end
   endtask

   task automatic test_random_traffic();
      int c = 0;
      apply_reset();
      req_rand  = 1'b1;
      ordy_mode = 2;
      rrdy_mode = 2;
      lat_max   = 4;
      while (c < 3000 && (c < 500 || (send_q.size() + pend_q.size() + exp_q.size()) != 0)) begin
         if (c < 500 && send_q.size() < 2) send_q.push_back(rand_word());
         drive();
         total++;
         if (req_rdy !== 1'(pend_q.size() < DEPTH)) begin
            bad++; $display("FAIL rnd_req_rdy_c%0d: got %b want %b", c, req_rdy, (pend_q.size() < DEPTH));
         end
         total++;
         if (operands_val !== 1'((pend_q.size() != 0) && (exp_q.size() < TAG_DEPTH))) begin
            bad++; $display("FAIL rnd_operands_val_c%0d: got %b want %b", c, operands_val, ((pend_q.size() != 0) && (exp_q.size() < TAG_DEPTH)));
         end
         if (operands_val && pend_q.size() != 0) begin
            total++;
            if ({operands_bits_A, operands_bits_B} !== pend_q[0]) begin
               bad++; $display("FAIL rnd_operands_bits_c%0d: got %h want %h", c, {operands_bits_A, operands_bits_B}, pend_q[0]);
            end
         end
         total++;
         if (resp_val !== 1'(result_val_in && (exp_q.size() != 0)) || result_rdy_out !== 1'(resp_rdy && (exp_q.size() != 0))) begin
            bad++; $display("FAIL rnd_resp_handshake_c%0d: resp_val=%b result_rdy_out=%b outstanding=%0d", c, resp_val, result_rdy_out, exp_q.size());
         end
         total++;
         if (resp_bits !== result_bits_in) begin
            bad++; $display("FAIL rnd_resp_passthru_c%0d: got %h want %h", c, resp_bits, result_bits_in);
         end
         if (f_resp) begin
            total++;
            if (exp_q.size() == 0 || {resp_tag, resp_bits} !== exp_q[0]) begin
               bad++; $display("FAIL rnd_resp_c%0d: got tag=%0d bits=%0d want %h", c, resp_tag, resp_bits, (exp_q.size() != 0) ? exp_q[0] : 20'h0);
            end
         end
         commit();
         c++;
      end
      total++; if (c >= 3000) begin bad++; $display("FAIL rnd_drain: %0d jobs left after %0d cycles", send_q.size() + pend_q.size() + exp_q.size(), c); end
      total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL rnd_err_orphan: got %b want 0", err_orphan); end
   endtask

   task automatic test_orphan_reset();
      int got = 0;
      apply_reset();
      force_orphan = 1'b1;
      drive();
      total++;
      if (result_rdy_out !== 1'b0 || resp_val !== 1'b0 || err_orphan !== 1'b0) begin
         bad++; $display("FAIL orphan_stall: result_rdy_out=%b resp_val=%b err_orphan=%b want 0 0 0", result_rdy_out, resp_val, err_orphan);
      end
      commit();
      force_orphan = 1'b0;
      drive();
      total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_flag: got %b want 1", err_orphan); end
      commit();
      lat_max = 3;
      for (int i = 0; i < 6; i++) send_q.push_back(rand_word());
      for (int c = 0; c < 6; c++) begin
         drive();
         commit();
      end
      total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
      // Assert reset between clock edges; everything must clear without an edge.
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL async_err_orphan: got %b want 0", err_orphan); end
      total++; if (req_rdy !== 1'b1 || operands_val !== 1'b0) begin bad++; $display("FAIL async_op_fifo: req_rdy=%b operands_val=%b want 1 0", req_rdy, operands_val); end
      total++; if (result_rdy_out !== 1'b0 || resp_tag !== 4'd0) begin bad++; $display("FAIL async_tag_fifo: result_rdy_out=%b resp_tag=%0d want 0 0", result_rdy_out, resp_tag); end
      apply_reset();
      send_q.push_back({16'd12, 16'd18});
      for (int c = 0; c < 100 && got < 1; c++) begin
         drive();
         if (f_resp) begin
            total++;
            if (resp_tag !== 4'd0 || resp_bits !== 16'd6) begin
               bad++; $display("FAIL post_reset_resp: got tag=%0d bits=%0d want tag=0 bits=6", resp_tag, resp_bits);
            end
            got++;
         end
         commit();
      end
      total++; if (got != 1) begin bad++; $display("FAIL post_reset_timeout: got %0d responses want 1", got); end
   endtask

`ifdef GCD_REQ_STATS_EN
   task automatic test_stats();
      int got = 0;
      apply_reset();
      ordy_mode = 2;
      rrdy_mode = 2;
      for (int i = 0; i < 7; i++) send_q.push_back(rand_word());
      for (int c = 0; c < 500 && got < 7; c++) begin
         drive();
         if (f_resp) got++;
         commit();
      end
      @(negedge clk);
      #1;
      total++; if (stat_issued !== 16'd7) begin bad++; $display("FAIL stat_issued: got %0d want 7", stat_issued); end
      total++; if (stat_returned !== 16'd7) begin bad++; $display("FAIL stat_returned: got %0d want 7", stat_returned); end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b1;
      req_val        = 1'b0;
      req_bits       = '0;
      operands_rdy   = 1'b0;
      result_val_in  = 1'b0;
      result_bits_in = '0;
      resp_rdy       = 1'b0;
      force_orphan   = 1'b0;
      req_rand       = 1'b0;
      ordy_mode      = 1;
      rrdy_mode      = 1;
      lat_max        = 2;
      model_tag      = 0;
      test_reset();
      test_single();
      test_burst();
      test_tag_wrap();
      test_back_pressure();
      test_random_traffic();
      test_orphan_reset();
`ifdef GCD_REQ_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gcd_req_queue.md
# gcd_req_queue

Request-side front end for `gcd_coprocessor`, sitting directly upstream of it and also wrapping its result port. Accepts packed 32-bit operand words `{A, B}` from a host stream and buffers them in an operand FIFO. Issues the buffered words to the coprocessor over its val/rdy operand interface and tags each issued job with a sequence number. Returns each coprocessor result to the host paired with the tag of the job that produced it.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TAG_W`, 4: sequence tag width.
- `TAG_DEPTH`, 2: tag FIFO entries, which bounds the number of jobs in flight inside the coprocessor; power of two, ≥1.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_val` in 1: host operand word valid.
- `req_bits` in 32: `[31:16]` = A, `[15:0]` = B.
- `req_rdy` out 1: operand FIFO can accept.
- `operands_val` out 1: to coprocessor.
- `operands_bits_A` out 16: to coprocessor.
- `operands_bits_B` out 16: to coprocessor.
- `operands_rdy` in 1: from coprocessor.
- `result_val_in` in 1: coprocessor `result_val`.
- `result_bits_in` in 16: coprocessor `result_bits`.
- `result_rdy_out` out 1: drives coprocessor `result_rdy`.
- `resp_val` out 1: tagged result valid to host.
- `resp_bits` out 16: GCD value.
- `resp_tag` out TAG_W: tag of the originating job.
- `resp_rdy` in 1: host ready.
- `err_orphan` out 1: sticky; set when a result arrives while no tag is outstanding.

## Operation
- Host accept: a word is accepted when `req_val && req_rdy`. `req_rdy = (op_count != DEPTH)`. It does not look ahead to a pop in the same cycle.
- Issue gate: `operands_val = !op_empty && !tag_full`. A and B are driven from the operand FIFO head.
- Issue: occurs when `operands_val && operands_rdy`. On issue:
  - the operand FIFO pops;
  - `tag_ctr` is pushed into the tag FIFO;
  - `tag_ctr` increments modulo 2^TAG_W.
- Result path, combinational, no extra register stage:
  - `resp_val = result_val_in && !tag_empty`
  - `resp_bits = result_bits_in`
  - `resp_tag` = tag FIFO head
  - `result_rdy_out = resp_rdy && !tag_empty`
- Response: completes on `resp_val && resp_rdy`, which pops the tag FIFO.
- Orphan result: `result_val_in && tag_empty` leaves `result_rdy_out` low, so the result stalls, and sets `err_orphan`. `err_orphan` clears only on reset.
- Ordering: results return in issue order. The coprocessor is in-order, so no reordering logic is needed.
- Simultaneous events:
  - Push and pop on the operand FIFO in the same cycle: `op_count` is unchanged and both take effect.
  - Issue and response in the same cycle: the tag FIFO pushes and pops and its count is unchanged.
- Reset mid-operation: both FIFOs empty, `tag_ctr = 0`, `err_orphan = 0`. Any job already inside the coprocessor is discarded by the coprocessor's own reset, which shares the same `reset`.

## Timing
- Reset values:
  - `req_rdy = 1`
  - `operands_val = 0`, `operands_bits_A = 0`, `operands_bits_B = 0`
  - `resp_val = 0`, `result_rdy_out = 0`
  - `resp_bits = result_bits_in` (pass-through)
  - `resp_tag = 0`, `err_orphan = 0`
- Word accepted at edge N: `operands_val` can be high no earlier than edge N+1, i.e. one cycle of FIFO latency.
- Result path: zero added latency.
- Operand FIFO full: `req_rdy` drops in the cycle after the DEPTH-th accept.
- Tag FIFO full: issue stalls with `operands_val = 0` even when `operands_rdy = 1`.
- FIFO pointers: log2(DEPTH) and log2(TAG_DEPTH) bits, with natural wrap.
- Counts: one extra bit each, so the full and empty states are distinct.

## Configuration
- `GCD_REQ_STATS_EN` defined: adds output ports `stat_issued[15:0]` and `stat_returned[15:0]`.
  - `stat_issued` increments on each issue handshake.
  - `stat_returned` increments on each response handshake.
  - Both wrap 0xFFFF→0 and reset to 0.
- `GCD_REQ_STATS_EN` undefined: neither port nor the counters exist; all other behaviour is identical.

## Structure
- Package `gcd_pkg`:
  - `GCD_W = 16`
  - `REQ_W = 2*GCD_W`
  - a typedef for the packed `{A, B}` word
  - default values of DEPTH, TAG_W and TAG_DEPTH
- Sub-module `gcd_fifo`: generic synchronous FIFO with width and depth parameters and push/pop/full/empty/head ports. Instantiated twice, once as the operand FIFO (width 32) and once as the tag FIFO (width TAG_W).
- The top level holds `tag_ctr`, `err_orphan`, the optional stats counters and the handshake gating.

## Test plan
- Single job, with a real `gcd_coprocessor` attached: `req_bits = {27, 15}` → `resp_bits = 3`, `resp_tag = 0`. A following word `{21, 49}` → `resp_bits = 7`, `resp_tag = 1`.
- Burst, coprocessor attached: back-to-back words `{25,30}`, `{19,27}`, `{40,40}`, `{250,190}`, `{5,250}`, `{0,0}` with `resp_rdy = 1`.
  - Required responses, in order: 5, 1, 40, 10, 5, 0, tagged 0..5.
  - `req_rdy` must drop after 4 outstanding un-issued words.
- Tag wrap: issue 17 jobs; the 17th returns with `resp_tag = 0`.
- Back-pressure, using a behavioral coprocessor model that accepts every cycle:
  - hold `resp_rdy = 0`; `operands_val` must stall after 2 issues;
  - raise `resp_rdy`; results drain in order and issue resumes.
- Orphan and reset:
  - drive `result_val_in = 1` with nothing issued → `err_orphan = 1` and `result_rdy_out = 0`;
  - assert `reset` mid-burst → `err_orphan`, both FIFOs and `tag_ctr` clear immediately, without waiting for a clock edge.
- With `GCD_REQ_STATS_EN` defined: after 7 jobs, `stat_issued = 7` and `stat_returned = 7`.
